// File: rtl/keypad_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_encoder
//  Description : Digit-entry front end for the microwave time-input path.
//                Synchronises ten raw one-hot digit keys, debounces presses
//                and releases, encodes the accepted key to BCD and issues a
//                fixed-length valid strobe plus a one-cycle new_key pulse.
//                One press yields exactly one event; the key must be
//                released (debounced) before the next press is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_encoder #(
  parameter int DEBOUNCE = 4,   // identical samples needed for press/release (2..15)
  parameter int HOLD     = 3    // cycles valid stays high per press (1..15)
) (
  input  logic       clock,
  input  logic       clear_n,
  input  logic       enable,
  input  logic [9:0] keys,
  output logic [3:0] code,
  output logic       valid,
  output logic       new_key,
  output logic       error
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_st_idle         = 2'd0;
  localparam logic [1:0] c_st_debounce     = 2'd1;
  localparam logic [1:0] c_st_strobe       = 2'd2;
  localparam logic [1:0] c_st_wait_release = 2'd3;

  // Counter limits narrowed to the 4-bit counter width; the legal parameter
  // ranges keep both at or below 15, so the counter never wraps.
  localparam logic [3:0] c_debounce_cnt = 4'(DEBOUNCE);
  localparam logic [3:0] c_hold_cnt     = 4'(HOLD);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [9:0] sync1_q,   sync1_d;     // first synchroniser stage
  logic [9:0] ks_q,      ks_d;        // second stage: the only key view used
  logic [9:0] latched_q, latched_d;   // key vector captured when a press starts
  logic [1:0] state_q,   state_d;
  logic [3:0] cnt_q,     cnt_d;       // shared debounce / hold / release counter
  logic [3:0] code_q,    code_d;
  logic       valid_q,   valid_d;
  logic       new_key_q, new_key_d;
  logic       error_q,   error_d;

  // Classification of the synchronised key vector.
  logic       ks_any;
  logic       ks_multi;
  logic       ks_onehot;
  logic       ks_same;
  logic [3:0] cnt_inc;

  // Index of the highest set bit; only ever applied to a one-hot vector.
  function automatic logic [3:0] f_encode(input logic [9:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

  // Classify ks: clearing the lowest set bit leaves a nonzero value only
  // when two or more keys are down.
  always_comb begin
    ks_any    = (ks_q != 10'd0);
    ks_multi  = ((ks_q & (ks_q - 10'd1)) != 10'd0);
    ks_onehot = ks_any && !ks_multi;
    ks_same   = (ks_q == latched_q);
    cnt_inc   = cnt_q + 4'd1;
  end

  // Two-flop synchroniser for the asynchronous key inputs.
  always_comb begin
    sync1_d = keys;
    ks_d    = sync1_q;
  end

  // Press/strobe/release sequencing; every output is computed here and
  // registered below.
  always_comb begin
    state_d   = state_q;
    latched_d = latched_q;
    cnt_d     = cnt_q;
    code_d    = code_q;      // code holds until the next accepted press
    valid_d   = valid_q;
    new_key_d = 1'b0;        // new_key is a single-cycle pulse
    error_d   = 1'b0;

    case (state_q)
      c_st_idle: begin
        // Multiple keys are reported regardless of enable.
        error_d = ks_multi;
        if (enable && ks_onehot) begin
          latched_d = ks_q;
          cnt_d     = 4'd1;
          state_d   = c_st_debounce;
        end
      end

      c_st_debounce: begin
        error_d = ks_multi;
        if (enable && ks_same) begin
          if (cnt_inc == c_debounce_cnt) begin
            // Press accepted: the first strobe cycle counts as hold cycle 1.
            state_d   = c_st_strobe;
            code_d    = f_encode(latched_q);
            valid_d   = 1'b1;
            new_key_d = 1'b1;
            cnt_d     = 4'd1;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          // Bounce, key change or enable drop abandons the press silently.
          state_d = c_st_idle;
          cnt_d   = 4'd0;
        end
      end

      c_st_strobe: begin
        // The strobe runs to completion whatever keys and enable do.
        if (cnt_q == c_hold_cnt) begin
          valid_d = 1'b0;
          cnt_d   = 4'd0;
          state_d = c_st_wait_release;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      c_st_wait_release: begin
        // Any activity restarts the quiet-period count, so a held key never
        // produces a second event.
        if (!ks_any) begin
          if (cnt_inc == c_debounce_cnt) begin
            cnt_d   = 4'd0;
            state_d = c_st_idle;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cnt_d = 4'd0;
        end
      end

      default: begin
        state_d = c_st_idle;
        cnt_d   = 4'd0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by clear_n.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      sync1_q   <= 10'd0;
      ks_q      <= 10'd0;
      latched_q <= 10'd0;
      state_q   <= c_st_idle;
      cnt_q     <= 4'd0;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
      new_key_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      ks_q      <= ks_d;
      latched_q <= latched_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      new_key_q <= new_key_d;
      error_q   <= error_d;
    end
  end

  assign code    = code_q;
  assign valid   = valid_q;
  assign new_key = new_key_q;
  assign error   = error_q;

endmodule
`default_nettype wire

// File: doc/keypad_encoder.md
# keypad_encoder

Digit-entry front end for the microwave time-input path. It samples the ten raw one-hot digit keys, synchronises and debounces them, and encodes the pressed key to BCD. It issues a fixed-length `valid` strobe plus a one-cycle `new_key` pulse per accepted press. `new_key` is the start/clear event consumed by the downstream delay counter and digit shift logic, so this block is the producer side of that timing interface. One press yields exactly one event; the key must be released (debounced) before the next press is accepted.

## Interface
- `DEBOUNCE`, default 4: consecutive identical synchronised samples required to accept a press or a release. Legal range 2–15.
- `HOLD`, default 3: cycles `valid` stays high per accepted press. Legal range 1–15.
- `clock`: input, 1 bit. System clock; all state updates on the rising edge.
- `clear_n`: input, 1 bit. Reset, asynchronous and active-low.
- `enable`: input, 1 bit. Accept new presses while high.
- `keys`: input, 10 bits. Raw, asynchronous, active-high digit keys; bit i is digit i.
- `code`: output, 4 bits. BCD digit of the last accepted key.
- `valid`: output, 1 bit. High for exactly `HOLD` cycles per accepted press.
- `new_key`: output, 1 bit. One-cycle pulse on the first cycle of `valid`.
- `error`: output, 1 bit. High while more than one key is seen in IDLE or DEBOUNCE.

## Operation
- **Reset** (`clear_n` low, at any time, including mid-strobe):
  - state goes to IDLE;
  - synchroniser, latched vector, and counters go to 0;
  - `code` = 0, `valid` = 0, `new_key` = 0, `error` = 0.
- **Synchroniser:** `keys` passes through 2 flops, giving `ks`. All decisions use `ks` only.
- **FSM states:** IDLE, DEBOUNCE, STROBE, WAIT_RELEASE. All outputs are registered.
- **IDLE:**
  - `enable` = 1 and exactly one bit of `ks` set: latch `ks`, set cnt = 1, go to DEBOUNCE.
  - Two or more bits set: `error` = 1, remain in IDLE.
  - `ks` = 0 or `enable` = 0: remain in IDLE, `error` = 0.
- **DEBOUNCE:**
  - `ks` equals the latched vector: cnt++. When cnt would reach `DEBOUNCE`, go to STROBE, load `code` = index of the latched bit, set `valid` = 1, `new_key` = 1, cnt = 1.
  - `ks` differs from the latched vector, or `enable` = 0: go to IDLE with no event. `error` is set if `ks` has two or more bits.
- **STROBE:**
  - `new_key` returns to 0 after one cycle.
  - `valid` is held until `HOLD` cycles have elapsed, then `valid` = 0 and the state goes to WAIT_RELEASE with cnt = 0.
  - Ignores `keys` and `enable`; the strobe always completes.
- **WAIT_RELEASE:**
  - `ks` = 0: cnt++. At cnt = `DEBOUNCE`, go to IDLE.
  - Any nonzero `ks` (a bounce or a held key): cnt = 0.
  - A key held indefinitely never produces a second event.
- **`code` retention:** `code` keeps its value after `valid` falls and changes only when the next press is accepted.
- **Counter width:** 4-bit counters. There is no wrap, because the parameter ranges keep cnt ≤ 15.

## Timing
- Reference point: the key rises and is stable before edge 1. Then:
  - `ks` is valid after edge 2;
  - IDLE samples it at edge 3;
  - `valid` and `new_key` rise after edge `DEBOUNCE`+2 (edge 6 at defaults);
  - `new_key` falls after edge 7;
  - `valid` falls after edge `DEBOUNCE`+2+`HOLD` (edge 9).
- **Minimum press:** a key high for fewer than `DEBOUNCE` consecutive sampled cycles produces no event.
- **Release:** `keys` = 0 from edge r onward lets the block return to IDLE after edge r+1+`DEBOUNCE`, provided the strobe has already ended. A new press is accepted from the following cycle.
- **`error` latency:** `error` follows `ks` with 1 cycle of latency (3 cycles from raw `keys`).

## Test plan
- **Single press:** after reset, `keys` = 10'b00_0010_0000 (digit 5) held for 20 cycles.
  - `code` = 4'd5 with `valid` high on cycles 6–8 and `new_key` high only on cycle 6.
  - Exactly one event, and `code` stays 5 afterwards.
- **Bounce:** digit 3 toggled high 2 cycles, low 1 cycle, high 2 cycles, then low → no `valid` and no `new_key`.
- **Held key, then repress:** digit 9 held for 50 cycles → exactly one event. Release for `DEBOUNCE`+2 cycles, press digit 9 again → a second event with `code` = 9.
- **Two keys:** digits 1 and 2 high together → `error` = 1 from cycle 3 while held, and no `valid`. Dropping digit 2 → normal event with `code` = 1.
- **Enable gating:** `enable` = 0 while digit 7 is held → no event. Raising `enable` mid-hold → event `DEBOUNCE` cycles after IDLE sees `enable`.
- **Reset mid-operation:** `clear_n` pulsed low during the 2nd `valid` cycle.
  - `valid`, `new_key`, `code`, and `error` go to 0 immediately, asynchronously.
  - With the key still held after reset, a fresh event occurs with `code` = the held digit.
